timer_bank: RTL and testbench

Multi-channel, parametrised programmable timer that generalises the single-channel memory-mapped timer: each of NUM_CH independent channels has its own compare value, prescaler, one-shot/periodic mode and sticky done flag. The block sits beside the data memory on the slow clkTimer domain. Software-visible registers are mirrored in dmem and delivered through a simple write port. Status and count values go back to the core for polling, with an optional interrupt line.

---
 rtl/timer_bank.sv | 79 +++++++
 tb/tb_timer_bank.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent prescaled compare timers with sticky done flags.
// Define TIMER_IRQ_EN to store per-channel IE bits and drive irq; otherwise irq is tied low.
module timer_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH = 32,
    parameter int PRESC_W = 8,
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                    clkTimer,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [1:0]              cfg_sel,
    input  logic [WIDTH-1:0]        cfg_wdata,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       running,
    output logic                    irq
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`ifdef TIMER_IRQ_EN
    logic [NUM_CH-1:0] ie;
    assign irq = |(done & ie);
`else
    assign irq = 1'b0;
`endif
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t state, state_n;
        logic [WIDTH-1:0] cmp, cnt, cnt_n;
        logic [PRESC_W-1:0] presc, pc, pc_n;
        logic periodic, done_q, done_n;
        logic sel_ch, ctl_wr, cmp_wr, clr, tick, match;
        // A compare or control write to this channel swallows a coincident tick.
        always_comb begin
            sel_ch = cfg_we && cfg_ch == CH_W'(i);
            ctl_wr = sel_ch && cfg_sel == 2'b01;
            cmp_wr = sel_ch && cfg_sel == 2'b00;
            clr = cfg_we && cfg_sel == 2'b10 && i < WIDTH && cfg_wdata[i % WIDTH];
            tick = state == RUN && pc == presc && !ctl_wr && !cmp_wr;
            match = tick && cnt == cmp;
            state_n = ctl_wr ? (cfg_wdata[0] ? RUN : IDLE) : (match && !periodic ? HALT : state);
            cnt_n = ctl_wr || (match && periodic) ? '0 : (tick && !match ? cnt + 1'b1 : cnt);
            pc_n = ctl_wr || tick ? '0 : (state == RUN && !cmp_wr ? pc + 1'b1 : pc);
            done_n = match || (done_q && !clr);
        end
        always_ff @(posedge clkTimer or posedge reset) begin
            if (reset) begin
                state <= IDLE;
                cnt <= '0;
                pc <= '0;
                cmp <= '0;
                presc <= '0;
                periodic <= 1'b0;
                done_q <= 1'b0;
            end else begin
                state <= state_n;
                cnt <= cnt_n;
                pc <= pc_n;
                done_q <= done_n;
                if (cmp_wr) cmp <= cfg_wdata;
                if (ctl_wr) begin
                    periodic <= cfg_wdata[1];
                    presc <= cfg_wdata[8 +: PRESC_W];
                end
            end
        end
`ifdef TIMER_IRQ_EN
        logic ie_q;
        always_ff @(posedge clkTimer or posedge reset) begin
            if (reset) ie_q <= 1'b0;
            else if (ctl_wr) ie_q <= cfg_wdata[2];
        end
        assign ie[i] = ie_q;
`endif
        assign count[i*WIDTH +: WIDTH] = cnt;
        assign done[i] = done_q;
        assign running[i] = state == RUN;
    end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed checks of timer_bank with a 12-bit counter build so wraps are short.
module tb_timer_bank;
    localparam int NUM_CH = 4, WIDTH = 12, PRESC_W = 4;
`ifdef TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    logic clkTimer = 1'b0, reset = 1'b0, cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0, cfg_sel = '0;
    logic [WIDTH-1:0] cfg_wdata = '0;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0] done, running;
    logic irq;
    int checks = 0, errors = 0;

    timer_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clkTimer(clkTimer), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .count(count), .done(done),
        .running(running), .irq(irq)
    );

    always #5 clkTimer = ~clkTimer;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(count[ch*WIDTH +: WIDTH]);
    endfunction

    // Called at a negedge; the write is sampled at the next posedge and we return at the following negedge.
    task automatic wr(input logic [1:0] ch, input logic [1:0] sel, input logic [WIDTH-1:0] d);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_sel = sel;
        cfg_wdata = d;
        @(negedge clkTimer);
        cfg_we = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clkTimer);
    endtask

    initial begin
        int seq[7] = '{0, 0, 1, 1, 2, 2, 0};
        #1 reset = 1'b1;
        @(negedge clkTimer);
        check("rst_count", 32'(count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_running", 32'(running), 0);
        check("rst_irq", 32'(irq), 0);
        reset = 1'b0;

        wr(0, 0, 5);
        wr(0, 1, 1);
        step(3);
        check("mid_count_before_rst", cnt(0), 3);
        reset = 1'b1;
        #1;
        check("async_rst_count", cnt(0), 0);
        check("async_rst_running", 32'(running), 0);
        check("async_rst_done", 32'(done), 0);
        step(2);
        check("rst_held_count", cnt(0), 0);
        reset = 1'b0;
        step(2);
        check("post_rst_idle_count", cnt(0), 0);

        wr(0, 0, 3);
        wr(0, 1, 12'h005);
        step(3);
        check("oneshot_cnt3", cnt(0), 3);
        check("oneshot_not_done", 32'(done[0]), 0);
        step(1);
        check("oneshot_done", 32'(done[0]), 1);
        check("oneshot_running", 32'(running[0]), 0);
        check("oneshot_irq", 32'(irq), 32'(IRQ_ON));
        step(2);
        check("oneshot_hold", cnt(0), 3);
        wr(0, 2, 1);
        check("oneshot_cleared", 32'(done[0]), 0);
        check("oneshot_irq_clear", 32'(irq), 0);

        wr(1, 0, 2);
        wr(1, 1, 12'h103);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step(1);
            check($sformatf("per_seq%0d", k), cnt(1), 32'(seq[k]));
            check($sformatf("per_done%0d", k), 32'(done[1]), 32'(k == 6));
        end
        wr(0, 2, 2);
        check("per_clear", 32'(done[1]), 0);
        step(4);
        check("per_not_yet", 32'(done[1]), 0);
        step(1);
        check("per_again", 32'(done[1]), 1);
        check("per_again_cnt", cnt(1), 0);
        check("per_running", 32'(running[1]), 1);
        wr(1, 1, 0);
        check("stop_running", 32'(running[1]), 0);
        check("stop_keeps_done", 32'(done[1]), 1);
        check("stop_count", cnt(1), 0);
        wr(0, 2, 12'hF);
        check("clear_all", 32'(done), 0);

        wr(0, 0, 1);
        wr(3, 0, 4);
        wr(3, 1, 1);
        wr(0, 1, 1);
        step(1);
        check("ind_e2", 32'(done), 0);
        step(1);
        check("ind_e3", 32'(done), 4'b0001);
        step(1);
        check("ind_e4", 32'(done), 4'b0001);
        step(1);
        check("ind_e5", 32'(done), 4'b1001);
        check("ind_cnt0", cnt(0), 1);
        check("ind_cnt3", cnt(3), 4);
        check("ind_cnt1", cnt(1), 0);
        check("ind_cnt2", cnt(2), 0);
        wr(0, 1, 0);
        wr(3, 1, 0);
        wr(0, 2, 12'hF);

        wr(0, 0, 2);
        wr(0, 1, 3);
        step(2);
        wr(0, 2, 1);
        check("collide_set_wins", 32'(done[0]), 1);
        check("collide_cnt", cnt(0), 0);
        wr(0, 2, 1);
        check("collide_later_clear", 32'(done[0]), 0);
        wr(0, 1, 0);

        wr(2, 0, 100);
        wr(2, 1, 1);
        step(10);
        check("low_cnt10", cnt(2), 10);
        wr(2, 0, 4);
        check("low_write_swallows_tick", cnt(2), 10);
        step(4085);
        check("low_cnt_max", cnt(2), 4095);
        check("low_no_done_max", 32'(done[2]), 0);
        step(1);
        check("low_wrap", cnt(2), 0);
        check("low_wrap_no_done", 32'(done[2]), 0);
        step(4);
        check("low_cnt4", cnt(2), 4);
        check("low_cnt4_no_done", 32'(done[2]), 0);
        step(1);
        check("low_done", 32'(done[2]), 1);
        check("low_hold", cnt(2), 4);
        check("low_halt", 32'(running[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
